// File: rtl/scope_tap.sv
// Leaf capture unit of the debug-scope tree: bit-serial command/response tap with a trigger-started probe buffer.
// Optional build macro SCOPE_DELTA_EN stores only changed samples, each tagged with a 16-bit cycle delta.
module scope_tap #(
    parameter logic [7:0]  TAP_ID = 8'h00,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] probes,
    input  logic             trigger,
    input  logic             bus_in,
    output logic             bus_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
`ifdef SCOPE_DELTA_EN
    localparam int unsigned EW = WIDTH + 16;
    localparam int unsigned PW = CW + 1;
`else
    localparam int unsigned EW = WIDTH;
    localparam int unsigned PW = CW;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, EXEC, TX} rx_state_e;
    typedef enum logic [1:0] {CAP_IDLE = 2'd0, CAP_ARMED = 2'd1, CAP_CAPTURE = 2'd2, CAP_DONE = 2'd3} cap_state_e;

    rx_state_e   rx_q;
    cap_state_e  cap_q;
    logic [3:0]  bit_cnt_q;
    logic [15:0] cmd_q;
    logic [31:0] tx_sr_q;
    logic [5:0]  tx_cnt_q;
    logic        bus_out_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [EW-1:0] mem [DEPTH];
`ifdef SCOPE_DELTA_EN
    logic [15:0]      delta_q;
    logic [WIDTH-1:0] last_q;
`endif

    logic          hit, do_start, do_stop, do_read, rsp_due, rd_ok, store, wr_en;
    logic [3:0]    op;
    logic [PW-1:0] words;
    logic [AW-1:0] rd_idx;
    logic [EW-1:0] rd_entry, wr_entry;
    logic [31:0]   rd_word, rsp;

    // Command decode, read-port mux and store qualification
    always_comb begin
        hit      = (rx_q == EXEC) && (cmd_q[15:8] == TAP_ID);
        op       = cmd_q[3:0];
        do_start = hit && (op == 4'd1);
        do_stop  = hit && (op == 4'd2);
        do_read  = hit && (op == 4'd4);
        rsp_due  = hit && ((op == 4'd3) || (op == 4'd4) || (op == 4'd5));
`ifdef SCOPE_DELTA_EN
        words    = {count_q, 1'b0};
        rd_idx   = rd_ptr_q[AW:1];
`else
        words    = count_q;
        rd_idx   = rd_ptr_q[AW-1:0];
`endif
        rd_ok    = rd_ptr_q < words;
        rd_entry = mem[rd_idx];
        rd_word  = '0;
        if (rd_ok) begin
`ifdef SCOPE_DELTA_EN
            rd_word = rd_ptr_q[0] ? 32'(rd_entry[WIDTH-1:0]) : 32'(rd_entry[EW-1:WIDTH]);
`else
            rd_word = 32'(rd_entry);
`endif
        end
        case (op)
            4'd3:    rsp = {2'(cap_q), 14'b0, 16'(count_q)};
            4'd4:    rsp = rd_word;
            4'd5:    rsp = {16'(DEPTH), 8'h00, 8'(WIDTH)};
            default: rsp = '0;
        endcase
        store = 1'b0;
`ifdef SCOPE_DELTA_EN
        wr_entry = {16'h0000, probes};
`else
        wr_entry = probes;
`endif
        case (cap_q)
            CAP_ARMED:   store = trigger;
            CAP_CAPTURE: begin
`ifdef SCOPE_DELTA_EN
                store    = (probes != last_q) || (delta_q == 16'hFFFF);
                wr_entry = {delta_q, probes};
`else
                store    = 1'b1;
`endif
            end
            default: store = 1'b0;
        endcase
        wr_en = store && !do_start;
    end

    // Buffer write port; a same-cycle READ sees the previous contents
    always_ff @(posedge clk) begin
        if (wr_en) mem[count_q[AW-1:0]] <= wr_entry;
    end

    // Serial command/response FSM and capture FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q      <= RX_IDLE;
            cap_q     <= CAP_IDLE;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            tx_sr_q   <= '0;
            tx_cnt_q  <= '0;
            bus_out_q <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
`ifdef SCOPE_DELTA_EN
            delta_q   <= '0;
            last_q    <= '0;
`endif
        end else begin
            case (rx_q)
                RX_IDLE: begin
                    bit_cnt_q <= '0;
                    if (bus_in) rx_q <= RX_SHIFT;
                end
                RX_SHIFT: begin
                    cmd_q     <= {cmd_q[14:0], bus_in};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) rx_q <= EXEC;
                end
                EXEC: begin
                    if (rsp_due) begin
                        bus_out_q <= 1'b1;
                        tx_sr_q   <= rsp;
                        tx_cnt_q  <= 6'd32;
                        rx_q      <= TX;
                    end else begin
                        rx_q <= RX_IDLE;
                    end
                end
                default: begin
                    if (tx_cnt_q != 6'd0) begin
                        bus_out_q <= tx_sr_q[31];
                        tx_sr_q   <= {tx_sr_q[30:0], 1'b0};
                        tx_cnt_q  <= tx_cnt_q - 6'd1;
                    end else begin
                        bus_out_q <= 1'b0;
                        rx_q      <= RX_IDLE;
                    end
                end
            endcase

            // START overrides any store or trigger in the same cycle
            if (do_start) begin
                cap_q    <= CAP_ARMED;
                count_q  <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_en) count_q <= count_q + CW'(1);
                if (do_read && rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
                case (cap_q)
                    CAP_ARMED:   if (trigger) cap_q <= CAP_CAPTURE;
                    CAP_CAPTURE: if (store && (count_q + CW'(1) == CW'(DEPTH))) cap_q <= CAP_DONE;
                    default:     ;
                endcase
                if (do_stop && ((cap_q == CAP_ARMED) || (cap_q == CAP_CAPTURE))) cap_q <= CAP_DONE;
`ifdef SCOPE_DELTA_EN
                if ((cap_q == CAP_ARMED) && trigger) begin
                    delta_q <= 16'd1;
                    last_q  <= probes;
                end else if (cap_q == CAP_CAPTURE) begin
                    if (store) begin
                        delta_q <= 16'd1;
                        last_q  <= probes;
                    end else begin
                        delta_q <= delta_q + 16'd1;
                    end
                end
`endif
            end
        end
    end

    assign bus_out = bus_out_q;

endmodule

// File: tb/tb_scope_tap.sv
// Directed bench for scope_tap (TAP_ID=0x05, WIDTH=12, DEPTH=16); delta checks build only with SCOPE_DELTA_EN.
module tb_scope_tap;
    localparam int unsigned WIDTH = 12;
    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  ID    = 8'h05;
`ifdef SCOPE_DELTA_EN
    localparam int NWORDS = 32;
`else
    localparam int NWORDS = 16;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             trigger;
    logic             bus_in;
    logic             bus_out;
    logic [WIDTH-1:0] probes;
    int errors = 0;
    int checks = 0;

    scope_tap #(.TAP_ID(ID), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .probes(probes), .trigger(trigger),
        .bus_in(bus_in), .bus_out(bus_out)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic send_frame(input logic [7:0] id, input logic [3:0] op);
        logic [15:0] cmd;
        cmd = {id, 4'h0, op};
        @(negedge clk) bus_in = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk) bus_in = cmd[i];
        end
    endtask

    task automatic command(input logic [7:0] id, input logic [3:0] op);
        send_frame(id, op);
        @(negedge clk) bus_in = 1'b0;
        @(negedge clk);
    endtask

    // ok reports 0 at k+1, start bit at k+2 and 0 again at k+35
    task automatic transact(input logic [7:0] id, input logic [3:0] op,
                            output logic [31:0] data, output logic ok);
        send_frame(id, op);
        ok = 1'b1;
        data = '0;
        @(negedge clk) bus_in = 1'b0;
        if (bus_out !== 1'b0) ok = 1'b0;
        @(negedge clk);
        if (bus_out !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk) data = {data[30:0], bus_out};
        end
        @(negedge clk);
        if (bus_out !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic ok;
        reset = 1'b1; bus_in = 1'b0; trigger = 1'b0; probes = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_out !== 1'b0) begin errors++; $display("FAIL reset_bus_out: got %b expected 0", bus_out); end
        reset = 1'b0;
        transact(ID, 4'd3, d, ok);
        checks++;
        if (d !== 32'h0000_0000 || ok !== 1'b1) begin
            errors++; $display("FAIL reset_status: got %08h ok=%b expected 00000000 ok=1", d, ok);
        end
    endtask

    task automatic test_info();
        logic [31:0] d;
        logic ok;
        transact(ID, 4'd5, d, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL info_framing: got ok=%b expected 1", ok); end
        checks++;
        if (d !== 32'h0010_000C) begin errors++; $display("FAIL info_data: got %08h expected 0010000c", d); end
    endtask

    task automatic test_id_mismatch();
        logic [31:0] d;
        logic ok;
        int ones;
        ones = 0;
        send_frame(8'h06, 4'd5);
        @(negedge clk) bus_in = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus_out !== 1'b0) ones++;
        end
        checks++;
        if (ones != 0) begin errors++; $display("FAIL mismatch_quiet: got %0d active cycles expected 0", ones); end
        transact(ID, 4'd3, d, ok);
        checks++;
        if (d !== 32'h0000_0000 || ok !== 1'b1) begin
            errors++; $display("FAIL mismatch_status: got %08h ok=%b expected 00000000 ok=1", d, ok);
        end
    endtask

    task automatic test_capture_full();
        logic [31:0] d, exp;
        logic ok;
        int bad;
        command(ID, 4'd1);
        for (int c = 0; c < 30; c++) begin
            probes = WIDTH'(c);
            trigger = (c == 10);
            @(negedge clk);
        end
        trigger = 1'b0;
        transact(ID, 4'd3, d, ok);
        checks++;
        if (d !== 32'hC000_0010 || ok !== 1'b1) begin
            errors++; $display("FAIL full_status: got %08h ok=%b expected c0000010 ok=1", d, ok);
        end
        bad = 0;
        for (int i = 0; i < NWORDS; i++) begin
`ifdef SCOPE_DELTA_EN
            exp = (i % 2 == 0) ? ((i == 0) ? 32'd0 : 32'd1) : 32'(10 + i / 2);
`else
            exp = 32'(10 + i);
`endif
            transact(ID, 4'd4, d, ok);
            checks++;
            if (d !== exp || ok !== 1'b1) begin
                errors++; bad++;
                $display("FAIL read_word%0d: got %08h expected %08h", i, d, exp);
            end
        end
        transact(ID, 4'd4, d, ok);
        checks++;
        if (d !== 32'h0 || ok !== 1'b1) begin errors++; $display("FAIL read_past_end: got %08h expected 00000000", d); end
    endtask

    task automatic test_stop_restart();
        logic [31:0] d;
        logic ok;
        command(ID, 4'd1);
        command(ID, 4'd2);
        transact(ID, 4'd3, d, ok);
        checks++;
        if (d !== 32'hC000_0000) begin errors++; $display("FAIL stop_armed_status: got %08h expected c0000000", d); end
        command(ID, 4'd1);
        probes = 12'hABC; trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        repeat (3) @(negedge clk);
        command(ID, 4'd1);
        transact(ID, 4'd3, d, ok);
        checks++;
        if (d !== 32'h4000_0000) begin errors++; $display("FAIL restart_status: got %08h expected 40000000", d); end
        transact(ID, 4'd4, d, ok);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL restart_read: got %08h expected 00000000", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic ok;
        logic [15:0] cmd;
        int ones;
        cmd = {ID, 4'h0, 4'd5};
        @(negedge clk) bus_in = 1'b1;
        for (int i = 15; i >= 9; i--) begin
            @(negedge clk) bus_in = cmd[i];
        end
        @(negedge clk) begin reset = 1'b1; bus_in = 1'b0; end
        @(negedge clk) reset = 1'b0;
        ones = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_out !== 1'b0) ones++;
        end
        checks++;
        if (ones != 0) begin errors++; $display("FAIL midframe_quiet: got %0d active cycles expected 0", ones); end
        transact(ID, 4'd3, d, ok);
        checks++;
        if (d !== 32'h0000_0000 || ok !== 1'b1) begin
            errors++; $display("FAIL midframe_status: got %08h ok=%b expected 00000000 ok=1", d, ok);
        end
    endtask

`ifdef SCOPE_DELTA_EN
    task automatic test_delta();
        logic [31:0] d;
        logic ok;
        logic [31:0] exp [4];
        exp[0] = 32'd0; exp[1] = 32'd3; exp[2] = 32'd5; exp[3] = 32'd4;
        command(ID, 4'd1);
        for (int c = 0; c < 7; c++) begin
            probes = (c < 5) ? 12'h003 : 12'h004;
            trigger = (c == 0);
            @(negedge clk);
        end
        trigger = 1'b0;
        command(ID, 4'd2);
        transact(ID, 4'd3, d, ok);
        checks++;
        if (d !== 32'hC000_0002) begin errors++; $display("FAIL delta_status: got %08h expected c0000002", d); end
        for (int i = 0; i < 4; i++) begin
            transact(ID, 4'd4, d, ok);
            checks++;
            if (d !== exp[i]) begin errors++; $display("FAIL delta_read%0d: got %08h expected %08h", i, d, exp[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_info();
        test_id_mismatch();
        test_capture_full();
        test_stop_restart();
        test_reset_midframe();
`ifdef SCOPE_DELTA_EN
        test_delta();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scope_tap.md
Name: scope_tap

Overview:
- Leaf capture unit of the debug-scope tree.
- Consumes one fan-out request line from the scope switch as a bit-serial command bus and drives one response line back into the switch's OR-combine.
- Records probe samples into an internal buffer once a trigger fires.
- Returns status and captured data serially to the host-side scope controller.

Parameters:
- TAP_ID, 0: 8-bit identifier. A tap responds only to commands carrying this ID.
- WIDTH, 32: probe width, 1..32. Read data is zero-extended to 32 bits.
- DEPTH, 256: capture buffer entries, a power of two from 2 to 4096.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- probes  in  WIDTH  signals to record
- trigger  in  1  capture trigger, level sampled each cycle
- bus_in  in  1  serial command line from the scope switch (req_out[i])
- bus_out  out  1  serial response line to the scope switch (rsp_in[i])

Behaviour:
- Clocking and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: bus_out=0, capture state IDLE, count=0, read pointer=0, command FSM in RX_IDLE. Reset mid-frame or mid-capture aborts everything and drops any partial frame.
- Command frame: bus_in idles at 0. A 1 sampled in RX_IDLE is the start bit. The next 16 cycles carry cmd[15:0], MSB first:
  - cmd[15:8] = tap id
  - cmd[3:0] = opcode
  - cmd[7:4] = reserved, ignored
- Command FSM: RX_IDLE -> RX_SHIFT (16 bits) -> EXEC (1 cycle) -> TX (33 cycles, only if a response is due) -> RX_IDLE.
- ID mismatch: the frame is consumed and discarded, bus_out stays 0, and no state changes.
- Opcodes:
  - 0 NOP: no effect, no response.
  - 1 START: clear count and read pointer; go to ARMED. Legal from any state.
  - 2 STOP: ARMED or CAPTURE -> DONE. No effect in IDLE or DONE.
  - 3 STATUS: respond {state[1:0], 14'b0, count[15:0]}. Encoding IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - 4 READ: respond buffer word at the read pointer, then increment the pointer. If pointer >= count (in words), respond 0 and do not increment.
  - 5 INFO: respond {DEPTH[15:0], 8'b0, WIDTH[7:0]}.
  - Other opcodes behave as NOP.
- Response timing: if the last command bit is on bus_in in cycle k, bus_out carries the start bit 1 in cycle k+2, then data[31:0] MSB first in cycles k+3..k+34, then returns to 0.
- bus_in is ignored during EXEC and TX; the host must not send during those cycles.
- Capture FSM:
  - IDLE: no capture activity.
  - ARMED -> CAPTURE when trigger=1. The probe value in that same cycle is entry 0.
  - CAPTURE: stores one entry per cycle; count increments.
  - CAPTURE -> DONE when count reaches DEPTH, or on STOP.
  - DONE: holds the buffer until START.
- Simultaneous events:
  - START executing in the same cycle as a trigger: START wins. Result is ARMED, count=0, and that trigger is lost.
  - STOP executing in the same cycle as a store: the store completes, then the state is DONE.
- Buffer write and READ may overlap in cycle; READ returns the old contents if addresses collide.
- Status count is DEPTH-exact, so it must fit 16 bits; DEPTH=4096 reports 4096.

Optional Feature:
- Macro: SCOPE_DELTA_EN.
- Defined:
  - In CAPTURE, an entry is stored only when probes differ from the last stored value, or when the 16-bit delta counter saturates at 0xFFFF.
  - The trigger-cycle sample is always stored.
  - Each entry holds {delta[15:0], data}, where delta is the number of cycles since the previous stored entry (0 for entry 0).
  - READ returns two words per entry: delta zero-extended first, then data.
  - Entries fill at the same rate as stores; DONE on DEPTH entries.
- Undefined: every cycle is stored, and READ returns one word per entry.

Test Plan:
- Reset, then INFO to TAP_ID=0x05 (WIDTH=12, DEPTH=16) -> response start bit at k+2, data 0x0010000C; bus_out=0 before and after.
- INFO with id 0x06 to a tap with TAP_ID 0x05 -> bus_out stays 0 for 40 cycles; a following STATUS returns 0x00000000.
- START; trigger high at cycle 10 with probes=cycle index -> STATUS after 20 cycles returns 0xC0000010. Sixteen READs return 10..25; a 17th READ returns 0.
- START; STOP before any trigger -> STATUS 0xC0000000. START issued again after CAPTURE has begun -> STATUS 0x40000000 and the old data is unreadable.
- Reset asserted at bit 7 of a frame, then a clean STATUS frame -> correct response, no residual bits.
- With SCOPE_DELTA_EN: trigger, then probes 0x3 held 5 cycles, then 0x4, then STOP -> count=2. READs return 0,3,5,4.
